mpdmac_sched: RTL and testbench
===============================

MPDMAC_SCHED -- requirements
Module: mpdmac_sched

Interface
REQ-001 Parameter NUM_CH, default 4, sets the number of requester channels (2..8).
REQ-002 Parameter MAX_WIDTH, default 61, sets the largest legal mat_width, so that padded width + 2 fits in 6 bits.
REQ-003 Port clk, input, 1, is the single clock.
REQ-004 Port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 Port enable_i, input, 1: when 0, no new grant is issued.
REQ-006 Port req_i, input, NUM_CH: per-channel job request, level, held until ack.
REQ-007 Port src_addr_i, input, NUM_CH x 32: per-channel source base address.
REQ-008 Port dst_addr_i, input, NUM_CH x 32: per-channel destination base address.
REQ-009 Port mat_width_i, input, NUM_CH x 6: per-channel source matrix width.
REQ-010 Port ack_o, input/output direction output, NUM_CH: one-cycle pulse that accepts the request.
REQ-011 Port cmpl_o, output, NUM_CH: one-cycle pulse when the job finishes.
REQ-012 Port err_o, output, NUM_CH: one-cycle pulse when a request is rejected.
REQ-013 Port eng_src_addr_o, output, 32: source address driven to the DMA engine.
REQ-014 Port eng_dst_addr_o, output, 32: destination address driven to the DMA engine.
REQ-015 Port eng_mat_width_o, output, 6: matrix width driven to the DMA engine.
REQ-016 Port eng_start_o, output, 1: start pulse to the engine.
REQ-017 Port eng_done_i, input, 1: engine done level; high means idle.
REQ-018 Port busy_o, output, 1: high while any state other than IDLE is active.
REQ-019 Port cur_ch_o, output, 3: index of the granted channel.
REQ-020 Port job_cnt_o, output, 16: count of completed jobs, saturating.

Function
REQ-021 States shall be IDLE, ARB, LAUNCH, BUSY and CMPL.
REQ-022 IDLE shall go to ARB when enable_i=1 and |req_i=1 and eng_done_i=1.
REQ-023 ARB shall pick the first requesting channel at or after rr_ptr+1 (mod NUM_CH), latch its src, dst and width into registers, and pulse ack_o for that channel.
- ARB shall take exactly one cycle.
REQ-024 If the latched width is below 2 or above MAX_WIDTH, ARB shall pulse err_o in place of ack_o for that channel, update rr_ptr, and return to IDLE.
- No engine start shall occur in that case.
REQ-025 For a legal width, ARB shall go to LAUNCH.
REQ-026 LAUNCH shall drive eng_start_o=1 for exactly one cycle, with the eng_* outputs stable from the latched registers, then go to BUSY.
REQ-027 BUSY shall stay until eng_done_i=1.
- The engine drops done on the cycle after start, so the first BUSY cycle already sees 0.
REQ-028 BUSY shall go to CMPL when eng_done_i=1.
REQ-029 CMPL shall pulse cmpl_o for the granted channel, increment job_cnt_o (saturating at 0xFFFF), set rr_ptr to the granted channel, and go to IDLE.
REQ-030 Back-to-back jobs shall have a minimum gap of 2 cycles from CMPL to the next eng_start_o (IDLE, then ARB).
REQ-031 A requester that deasserts req_i before ack shall simply not be selected; requests are not remembered.
REQ-032 Deasserting enable_i during LAUNCH or BUSY shall not abort the job; it only blocks the next grant.
REQ-033 eng_* outputs shall hold the last latched values outside LAUNCH and BUSY.
REQ-034 At most one bit of ack_o, err_o and cmpl_o combined shall be high in any cycle.

Reset
REQ-035 While rst=1, the block shall be in state IDLE, with rr_ptr=NUM_CH-1 (so channel 0 is served first), all latched registers 0, job_cnt_o=0, and all pulses, eng_start_o and busy_o at 0.
REQ-036 A reset asserted mid-job shall return the block to IDLE immediately.
- No cmpl_o shall be issued for the aborted job.
- The engine is reset on the same rst net.

Structure
REQ-037 The state enum and the MAX_WIDTH/MIN_WIDTH constants shall live in package mpdmac_pkg.
REQ-038 Round-robin selection shall be a sub-module mpdmac_rr_arb (req vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-039 Single job: ch0 req with width 4 -> ack0 pulse, then eng_start_o 1 cycle later with src/dst/width matching the request; after eng_done_i rises -> cmpl0 pulse, job_cnt=1.
REQ-040 Fairness: ch0..ch3 all requesting continuously -> grant order 0,1,2,3,0 across five jobs.
REQ-041 Illegal width: ch2 with width 1 or 62 -> err2 pulse, no eng_start_o, block returns to IDLE; a legal ch3 request is then served.
REQ-042 Engine busy: eng_done_i=0 while IDLE with req pending -> no grant until eng_done_i=1.
REQ-043 Reset mid-BUSY: rst pulse during BUSY -> busy_o=0 and no cmpl; the next request is served from channel 0 priority.
REQ-044 Saturation: force job_cnt to 0xFFFF, complete one job -> count stays 0xFFFF.

Source files
------------

// File: rtl/mpdmac_pkg.sv
// Shared types and width limits for the matrix-DMA job scheduler.
package mpdmac_pkg;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 61;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    BUSY,
    CMPL
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mpdmac_sched_if.sv
// Requester and engine signal bundle for mpdmac_sched; slave is the scheduler's view.
interface mpdmac_sched_if #(
  parameter int unsigned NUM_CH = 4
);
  logic                     enable_i;
  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH-1:0][31:0]  src_addr_i;
  logic [NUM_CH-1:0][31:0]  dst_addr_i;
  logic [NUM_CH-1:0][5:0]   mat_width_i;
  logic [NUM_CH-1:0]        ack_o;
  logic [NUM_CH-1:0]        cmpl_o;
  logic [NUM_CH-1:0]        err_o;
  logic [31:0]              eng_src_addr_o;
  logic [31:0]              eng_dst_addr_o;
  logic [5:0]               eng_mat_width_o;
  logic                     eng_start_o;
  logic                     eng_done_i;
  logic                     busy_o;
  logic [2:0]               cur_ch_o;
  logic [15:0]              job_cnt_o;

  modport slave (
    input  enable_i, req_i, src_addr_i, dst_addr_i, mat_width_i, eng_done_i,
    output ack_o, cmpl_o, err_o, eng_src_addr_o, eng_dst_addr_o,
           eng_mat_width_o, eng_start_o, busy_o, cur_ch_o, job_cnt_o
  );

  modport master (
    output enable_i, req_i, src_addr_i, dst_addr_i, mat_width_i, eng_done_i,
    input  ack_o, cmpl_o, err_o, eng_src_addr_o, eng_dst_addr_o,
           eng_mat_width_o, eng_start_o, busy_o, cur_ch_o, job_cnt_o
  );
endinterface

// File: rtl/mpdmac_rr_arb.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module mpdmac_rr_arb #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [2:0]        idx_o,
  output logic              valid_o
);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic [31:0] sum;
  logic [2:0]  cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    // k runs 1..NUM_CH so the pointer channel itself is checked last
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      sum  = 32'(ptr_i) + k;
      cand = 3'(sum % NUM_CH);
      if (!valid_o && ((req_i & (ONE << cand)) != '0)) begin
        valid_o = 1'b1;
        idx_o   = cand;
        gnt_o   = ONE << cand;
      end
    end
  end

endmodule

// File: rtl/mpdmac_sched.sv
// Arbitrates matrix-DMA jobs from NUM_CH requesters onto a single engine,
// rejecting illegal widths and counting completions.
module mpdmac_sched #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_WIDTH = mpdmac_pkg::MAX_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mpdmac_sched_if.slave  bus
);
  import mpdmac_pkg::*;

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  state_e            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        ch_q, ch_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [5:0]        wid_q, wid_d;
  logic [15:0]       job_cnt_q, job_cnt_d;

  logic [NUM_CH-1:0] gnt;
  logic [2:0]        gidx;
  logic              gvalid;
  logic [31:0]       sel_src, sel_dst;
  logic [5:0]        sel_wid;
  logic              wid_ok;
  logic [NUM_CH-1:0] ack, err, cmpl;
  logic              start;

  mpdmac_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req_i   (bus.req_i),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_wid = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        sel_src = bus.src_addr_i[k];
        sel_dst = bus.dst_addr_i[k];
        sel_wid = bus.mat_width_i[k];
      end
    end
  end

  assign wid_ok = (32'(sel_wid) >= MIN_WIDTH) && (32'(sel_wid) <= MAX_WIDTH);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    ch_d      = ch_q;
    src_d     = src_q;
    dst_d     = dst_q;
    wid_d     = wid_q;
    job_cnt_d = job_cnt_q;
    ack       = '0;
    err       = '0;
    cmpl      = '0;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_i && (|bus.req_i) && bus.eng_done_i) state_d = ARB;
      end
      ARB: begin
        // a requester that dropped out after IDLE leaves nothing to grant
        state_d = IDLE;
        if (gvalid) begin
          ch_d  = gidx;
          src_d = sel_src;
          dst_d = sel_dst;
          wid_d = sel_wid;
          if (wid_ok) begin
            ack     = gnt;
            state_d = LAUNCH;
          end else begin
            err  = gnt;
            rr_d = gidx;
          end
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.eng_done_i) state_d = CMPL;
      end
      CMPL: begin
        cmpl      = ONE << ch_q;
        job_cnt_d = sat_inc16(job_cnt_q);
        rr_d      = ch_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 3'(NUM_CH - 1);
      ch_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      wid_q     <= '0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      ch_q      <= ch_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      wid_q     <= wid_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  assign bus.ack_o           = ack;
  assign bus.err_o           = err;
  assign bus.cmpl_o          = cmpl;
  assign bus.eng_start_o     = start;
  assign bus.eng_src_addr_o  = src_q;
  assign bus.eng_dst_addr_o  = dst_q;
  assign bus.eng_mat_width_o = wid_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.cur_ch_o        = ch_q;
  assign bus.job_cnt_o       = job_cnt_q;

endmodule

// File: tb/tb_mpdmac_sched.sv
// Self-checking bench for mpdmac_sched: vector table plus directed corner sequences,
// with a scoreboard queue of expected grants checked by a negedge monitor.
module tb_mpdmac_sched;

  localparam int unsigned NCH = 4;

  typedef struct {
    logic [3:0] mask;
    logic [5:0] width;
    int         exp_ch;
    bit         exp_err;
  } vec_t;

  typedef struct {
    int          ch;
    bit          err;
    logic [31:0] src;
    logic [31:0] dst;
    logic [5:0]  w;
  } exp_t;

  logic clk;
  logic rst;
  mpdmac_sched_if #(.NUM_CH(NCH)) bus ();

  mpdmac_sched #(.NUM_CH(NCH), .MAX_WIDTH(61)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs [12];
  exp_t sbq  [$];

  // engine model: done drops the cycle after start, returns after eng_len cycles
  int eng_len  = 3;
  int eng_left = 0;
  bit eng_hold = 0;

  always @(posedge clk or posedge rst) begin
    if (rst)                  eng_left <= 0;
    else if (bus.eng_start_o) eng_left <= eng_len;
    else if (eng_left != 0)   eng_left <= eng_left - 1;
  end
  assign bus.eng_done_i = (eng_left == 0) && !eng_hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s: got unexpected/missing event, required expected timing", name);
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic exp_t mk(input int v, input int ch, input bit err, input logic [5:0] w);
    exp_t e;
    e.ch  = ch;
    e.err = err;
    e.src = 32'hA000_0000 + 32'(v * 256 + ch);
    e.dst = 32'hB000_0000 + 32'(v * 256 + ch * 16);
    e.w   = w;
    return e;
  endfunction

  task automatic set_data(input int v, input logic [5:0] w);
    for (int c = 0; c < 4; c++) begin
      bus.src_addr_i[c]  = 32'hA000_0000 + 32'(v * 256 + c);
      bus.dst_addr_i[c]  = 32'hB000_0000 + 32'(v * 256 + c * 16);
      bus.mat_width_i[c] = w;
    end
  endtask

  // monitor state
  int          cyc = 0;
  int          ack_cyc = 0;
  bit          pend_start = 0;
  bit          pend_cmpl = 0;
  bit          chk_cnt = 0;
  exp_t        cur;
  logic [15:0] exp_cnt = '0;
  int          onehot_viol = 0;
  int          grant_events = 0;
  int          cmpl_events = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      pend_start = 0;
      pend_cmpl  = 0;
      chk_cnt    = 0;
    end else begin
      if (chk_cnt) begin
        check("job_cnt", 32'(bus.job_cnt_o), 32'(exp_cnt));
        chk_cnt = 0;
      end
      if ($countones({bus.ack_o, bus.err_o, bus.cmpl_o}) > 1) onehot_viol++;
      if (|(bus.ack_o | bus.err_o)) begin
        grant_events++;
        if (sbq.size() == 0) begin
          fail_evt("unexpected_grant");
        end else begin
          e = sbq.pop_front();
          check("grant_ch", 32'(oh2idx(bus.ack_o | bus.err_o)), 32'(e.ch));
          check("grant_is_err", 32'(|bus.err_o), 32'(e.err));
          if (!e.err) begin
            cur        = e;
            pend_start = 1;
            ack_cyc    = cyc;
          end
        end
      end
      if (bus.eng_start_o) begin
        if (!pend_start) begin
          fail_evt("spurious_start");
        end else begin
          check("start_latency", 32'(cyc - ack_cyc), 32'd1);
          check("eng_src", bus.eng_src_addr_o, cur.src);
          check("eng_dst", bus.eng_dst_addr_o, cur.dst);
          check("eng_width", 32'(bus.eng_mat_width_o), 32'(cur.w));
          check("cur_ch", 32'(bus.cur_ch_o), 32'(cur.ch));
          pend_start = 0;
          pend_cmpl  = 1;
        end
      end
      if (|bus.cmpl_o) begin
        cmpl_events++;
        if (!pend_cmpl) begin
          fail_evt("spurious_cmpl");
        end else begin
          check("cmpl_ch", 32'(oh2idx(bus.cmpl_o)), 32'(cur.ch));
          exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
          chk_cnt   = 1;
          pend_cmpl = 0;
        end
      end
    end
  end

  task automatic wait_grant(input string tag);
    bit got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      got = |(bus.ack_o | bus.err_o);
    end
    if (!got) fail_evt({tag, "_grant_timeout"});
    @(posedge clk);
    #1;
    bus.req_i = '0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      done = !bus.busy_o && !pend_start && !pend_cmpl;
    end
    if (!done) fail_evt({tag, "_idle_timeout"});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int ge;
    int ce;
    rst          = 1'b1;
    bus.enable_i = 1'b1;
    bus.req_i    = '0;
    set_data(0, 6'd4);

    // round-robin expectations walked by hand from reset pointer = 3
    vecs[0]  = '{4'b1111, 6'd4,  0, 1'b0};
    vecs[1]  = '{4'b1111, 6'd5,  1, 1'b0};
    vecs[2]  = '{4'b1111, 6'd8,  2, 1'b0};
    vecs[3]  = '{4'b1111, 6'd2,  3, 1'b0};
    vecs[4]  = '{4'b1111, 6'd61, 0, 1'b0};
    vecs[5]  = '{4'b0100, 6'd1,  2, 1'b1};
    vecs[6]  = '{4'b0100, 6'd62, 2, 1'b1};
    vecs[7]  = '{4'b1000, 6'd4,  3, 1'b0};
    vecs[8]  = '{4'b0110, 6'd0,  1, 1'b1};
    vecs[9]  = '{4'b0101, 6'd63, 2, 1'b1};
    vecs[10] = '{4'b0011, 6'd10, 0, 1'b0};
    vecs[11] = '{4'b1010, 6'd7,  1, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_start", 32'(bus.eng_start_o), 32'd0);
    check("rst_pulses", 32'({bus.ack_o, bus.err_o, bus.cmpl_o}), 32'd0);
    check("rst_job_cnt", 32'(bus.job_cnt_o), 32'd0);
    check("rst_eng_src", bus.eng_src_addr_o, 32'd0);
    check("rst_eng_width", 32'(bus.eng_mat_width_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      set_data(v, vecs[v].width);
      sbq.push_back(mk(v, vecs[v].exp_ch, vecs[v].exp_err, vecs[v].width));
      bus.req_i = vecs[v].mask;
      wait_grant("vec");
      wait_idle("vec");
    end

    // engine not idle: request pending but no grant until done rises
    eng_hold = 1;
    ge = grant_events;
    set_data(20, 6'd9);
    sbq.push_back(mk(20, 2, 1'b0, 6'd9));
    bus.req_i = 4'b0100;
    repeat (8) @(negedge clk);
    check("hold_no_grant", 32'(grant_events), 32'(ge));
    check("hold_busy", 32'(bus.busy_o), 32'd0);
    eng_hold = 0;
    wait_grant("hold");
    wait_idle("hold");

    // dropping enable mid-job finishes the job but blocks the next grant
    set_data(21, 6'd12);
    sbq.push_back(mk(21, 3, 1'b0, 6'd12));
    bus.req_i = 4'b1000;
    wait_grant("en");
    bus.enable_i = 1'b0;
    wait_idle("en");
    ge = grant_events;
    set_data(22, 6'd3);
    bus.req_i = 4'b0001;
    repeat (6) @(negedge clk);
    check("dis_no_grant", 32'(grant_events), 32'(ge));
    check("dis_busy", 32'(bus.busy_o), 32'd0);
    sbq.push_back(mk(22, 0, 1'b0, 6'd3));
    bus.enable_i = 1'b1;
    wait_grant("en2");
    wait_idle("en2");

    // saturation: hold the counter at max across an idle edge, then complete a job
    force dut.job_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.job_cnt_q;
    exp_cnt = 16'hFFFF;
    set_data(23, 6'd6);
    sbq.push_back(mk(23, 1, 1'b0, 6'd6));
    bus.req_i = 4'b0010;
    wait_grant("sat");
    wait_idle("sat");

    // reset during BUSY aborts without completion and restores ch0 priority
    eng_len = 20;
    set_data(24, 6'd4);
    sbq.push_back(mk(24, 2, 1'b0, 6'd4));
    bus.req_i = 4'b0100;
    wait_grant("abort");
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy_o), 32'd1);
    ce  = cmpl_events;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy_rst", 32'(bus.busy_o), 32'd0);
    check("abort_start_rst", 32'(bus.eng_start_o), 32'd0);
    rst     = 1'b0;
    exp_cnt = '0;
    eng_len = 3;
    repeat (3) @(negedge clk);
    check("abort_no_cmpl", 32'(cmpl_events), 32'(ce));
    check("abort_job_cnt", 32'(bus.job_cnt_o), 32'd0);
    set_data(25, 6'd5);
    sbq.push_back(mk(25, 0, 1'b0, 6'd5));
    bus.req_i = 4'b1111;
    wait_grant("post_rst");
    wait_idle("post_rst");

    check("sb_empty", 32'(sbq.size()), 32'd0);
    check("pulse_onehot", 32'(onehot_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
